// File: rtl/wave_meter_pkg.sv
// Shared types and threshold helpers for the wave_meter block.
package wave_meter_pkg;

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  function automatic int unsigned mid_of(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic int unsigned low_th(input int unsigned w, input int unsigned hyst);
    return mid_of(w) - hyst;
  endfunction

  function automatic int unsigned high_th(input int unsigned w, input int unsigned hyst);
    return mid_of(w) + hyst;
  endfunction

endpackage

// File: rtl/wave_meter_xdet.sv
// Rising midpoint crossing detector with hysteresis: a low sample arms,
// a high sample while armed is a crossing and disarms.
module wave_meter_xdet #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    LOW_TH  = 8'd120,
  parameter logic [W-1:0]    HIGH_TH = 8'd136
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  input  logic         clear,
  output logic         crossing
);

  logic armed_q;
  logic armed_d;

  always_comb begin
    crossing = sample_valid && !rst && armed_q && (sample >= HIGH_TH);
  end

  always_comb begin
    armed_d = armed_q;
    if (sample_valid) begin
      // clear (timeout) wins over re-arming on the same sample
      if (clear || crossing) begin
        armed_d = 1'b0;
      end else if (sample < LOW_TH) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/wave_meter.sv
// Measures period and min/max of each cycle between consecutive rising
// midpoint crossings of an unsigned sample stream.
module wave_meter
  import wave_meter_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned HYST       = 8,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned MAX_PERIOD = (2 ** PERIOD_W) - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [W-1:0]        sample,
  output logic                result_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [W-1:0]        min_val,
  output logic [W-1:0]        max_val,
  output logic                timeout,
  output logic                locked
);

  localparam logic [W-1:0]        LOW_TH  = W'(low_th(W, HYST));
  localparam logic [W-1:0]        HIGH_TH = W'(high_th(W, HYST));
  localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [W-1:0]        run_min_q, run_min_d;
  logic [W-1:0]        run_max_q, run_max_d;
  logic                result_valid_q, result_valid_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [W-1:0]        min_val_q, min_val_d;
  logic [W-1:0]        max_val_q, max_val_d;
  logic                timeout_q, timeout_d;
  logic                crossing;
  logic                xdet_clear;

  wave_meter_xdet #(
    .W       (W),
    .LOW_TH  (LOW_TH),
    .HIGH_TH (HIGH_TH)
  ) u_xdet (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .clear        (xdet_clear),
    .crossing     (crossing)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    run_min_d      = run_min_q;
    run_max_d      = run_max_q;
    result_valid_d = 1'b0;
    period_d       = period_q;
    min_val_d      = min_val_q;
    max_val_d      = max_val_q;
    timeout_d      = timeout_q;
    xdet_clear     = 1'b0;

    if (sample_valid) begin
      case (state_q)
        SEEK: begin
          if (crossing) begin
            state_d   = MEASURE;
            count_d   = ONE;
            run_min_d = sample;
            run_max_d = sample;
          end
        end
        MEASURE: begin
          if (crossing) begin
            // the crossing sample closes this window and starts the next
            result_valid_d = 1'b1;
            period_d       = count_q;
            min_val_d      = run_min_q;
            max_val_d      = run_max_q;
            timeout_d      = 1'b0;
            count_d        = ONE;
            run_min_d      = sample;
            run_max_d      = sample;
          end else if (count_q == MAX_CNT) begin
            result_valid_d = 1'b1;
            period_d       = MAX_CNT;
            min_val_d      = run_min_q;
            max_val_d      = run_max_q;
            timeout_d      = 1'b1;
            state_d        = SEEK;
            xdet_clear     = 1'b1;
            count_d        = '0;
            run_min_d      = '1;
            run_max_d      = '0;
          end else begin
            count_d = count_q + ONE;
            if (sample < run_min_q) run_min_d = sample;
            if (sample > run_max_q) run_max_d = sample;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SEEK;
      count_q        <= '0;
      run_min_q      <= '1;
      run_max_q      <= '0;
      result_valid_q <= 1'b0;
      period_q       <= '0;
      min_val_q      <= '0;
      max_val_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      run_min_q      <= run_min_d;
      run_max_q      <= run_max_d;
      result_valid_q <= result_valid_d;
      period_q       <= period_d;
      min_val_q      <= min_val_d;
      max_val_q      <= max_val_d;
      timeout_q      <= timeout_d;
    end
  end

  assign result_valid = result_valid_q;
  assign period       = period_q;
  assign min_val      = min_val_q;
  assign max_val      = max_val_q;
  assign timeout      = timeout_q;
  assign locked       = (state_q == MEASURE);

endmodule

// File: tb/tb_wave_meter.sv
// Self-checking bench for wave_meter: scoreboard of expected results plus
// a short threshold table and a timeout instance with MAX_PERIOD=100.
module tb_wave_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample = 8'd0;

  logic        result_valid, timeout, locked;
  logic [15:0] period;
  logic [7:0]  min_val, max_val;

  logic        t_rv, t_timeout, t_locked;
  logic [15:0] t_period;
  logic [7:0]  t_min, t_max;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  typedef struct {
    int   edge_no;
    int   per;
    int   mn;
    int   mx;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       lk;
    bit         push;
    int         per;
    int         mn;
    int         mx;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  wave_meter dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .result_valid (result_valid),
    .period       (period),
    .min_val      (min_val),
    .max_val      (max_val),
    .timeout      (timeout),
    .locked       (locked)
  );

  wave_meter #(.MAX_PERIOD(100)) dut_t (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .result_valid (t_rv),
    .period       (t_period),
    .min_val      (t_min),
    .max_val      (t_max),
    .timeout      (t_timeout),
    .locked       (t_locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle; if push, the DUT must publish at the edge that accepts it.
  task automatic step(input logic v, input logic [7:0] s, input bit push,
                      input int per, input int mn, input int mx);
    exp_t e;
    sample_valid = v;
    sample = s;
    if (push) begin
      e.edge_no = edge_cnt + 1;
      e.per = per;
      e.mn = mn;
      e.mx = mx;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    sample = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_min"}, min_val, 0);
    chk({tag, "_max"}, max_val, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  // Scoreboard monitor: every pulse must match the queue head at the right edge.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rv_edge", edge_cnt, e.edge_no);
        chk("period", period, e.per);
        chk("min_val", min_val, e.mn);
        chk("max_val", max_val, e.mx);
        chk("timeout", timeout, 0);
        $display("result edge=%0d period=%0d min=%0d max=%0d", edge_cnt, period, min_val, max_val);
      end
    end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
      chk("missing_pulse", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    tbl[0]  = '{1'b1, 8'd135, 1'b0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 8'd119, 1'b0, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b1, 8'd136, 1'b1, 1'b0, 0, 0, 0};
    tbl[3]  = '{1'b1, 8'd135, 1'b1, 1'b0, 0, 0, 0};
    tbl[4]  = '{1'b1, 8'd120, 1'b1, 1'b0, 0, 0, 0};
    tbl[5]  = '{1'b1, 8'd200, 1'b1, 1'b0, 0, 0, 0};
    tbl[6]  = '{1'b1, 8'd119, 1'b1, 1'b0, 0, 0, 0};
    tbl[7]  = '{1'b0, 8'd200, 1'b1, 1'b0, 0, 0, 0};
    tbl[8]  = '{1'b1, 8'd136, 1'b1, 1'b1, 5, 119, 200};
    tbl[9]  = '{1'b1, 8'd0,   1'b1, 1'b0, 0, 0, 0};
    tbl[10] = '{1'b1, 8'd135, 1'b1, 1'b0, 0, 0, 0};
    tbl[11] = '{1'b1, 8'd136, 1'b1, 1'b1, 3, 0, 136};

    // reset state
    do_reset();
    chk_zero("reset");

    // square wave 0x10 / 255x10
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 10; j++) step(1'b1, 8'd0, 1'b0, 0, 0, 0);
      for (int j = 0; j < 10; j++) begin
        step(1'b1, 8'd255, (k > 0) && (j == 0), 20, 0, 255);
        if (k == 0 && j == 0) chk("sq_locked", locked, 1);
      end
    end

    // ramp, first two cycles clean, then with random valid gaps
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        if (r >= 2 && $urandom_range(0, 3) == 0)
          step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 0, 0, 0);
        step(1'b1, 8'(i), (r > 0) && (i == 136), 256, 0, 255);
      end
    end

    // noise inside the hysteresis band
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      step(1'b1, 8'(123 + $urandom_range(0, 10)), 1'b0, 0, 0, 0);
      chk("noise_locked", locked, 0);
    end

    // timeout on the MAX_PERIOD=100 instance
    do_reset();
    for (int j = 0; j < 10; j++) step(1'b1, 8'd0, 1'b0, 0, 0, 0);
    step(1'b1, 8'd255, 1'b0, 0, 0, 0);
    chk("to_locked_on", t_locked, 1);
    for (int j = 0; j < 99; j++) begin
      step(1'b1, 8'd200, 1'b0, 0, 0, 0);
      if (t_rv !== 1'b0) chk("to_early_rv", t_rv, 0);
    end
    chk("to_locked_pre", t_locked, 1);
    step(1'b1, 8'd200, 1'b0, 0, 0, 0);
    chk("to_rv", t_rv, 1);
    chk("to_period", t_period, 100);
    chk("to_min", t_min, 200);
    chk("to_max", t_max, 255);
    chk("to_timeout", t_timeout, 1);
    $display("timeout result period=%0d min=%0d max=%0d", t_period, t_min, t_max);
    step(1'b1, 8'd200, 1'b0, 0, 0, 0);
    chk("to_rv_single", t_rv, 0);
    chk("to_locked_off", t_locked, 0);
    chk("to_hold", t_timeout, 1);

    // reset mid-window
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 10; j++) step(1'b1, 8'd0, 1'b0, 0, 0, 0);
      for (int j = 0; j < 10; j++) step(1'b1, 8'd255, (k == 1) && (j == 0), 20, 0, 255);
    end
    for (int j = 0; j < 5; j++) step(1'b1, 8'd0, 1'b0, 0, 0, 0);
    chk("mid_queue", exp_q.size(), 0);
    do_reset();
    chk_zero("midrst");
    for (int j = 0; j < 5; j++) step(1'b1, 8'd255, 1'b0, 0, 0, 0);
    chk("midrst_unarmed", locked, 0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 10; j++) step(1'b1, 8'd0, 1'b0, 0, 0, 0);
      for (int j = 0; j < 10; j++) step(1'b1, 8'd255, (k == 1) && (j == 0), 20, 0, 255);
    end

    // threshold boundaries, table-driven
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].push, tbl[i].per, tbl[i].mn, tbl[i].mx);
      chk($sformatf("thr_locked_%0d", i), locked, tbl[i].lk);
    end

    repeat (3) step(1'b0, 8'd0, 1'b0, 0, 0, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
